// File: rtl/usr_access_gate.sv
// usr_access_gate: user-ID access check that queues each grant decision together with its (masked) data.
module usr_access_gate #(
  parameter int DATA_W = 8,
  parameter int ID_W = 3,
  parameter int DEPTH = 4,
  parameter logic [2**ID_W-1:0] DEFAULT_MASK = 8'h10,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic [DATA_W-1:0] req_data,
  input  logic              cfg_we,
  input  logic [2**ID_W-1:0] cfg_mask,
  input  logic              cfg_lock,
  output logic              locked,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_data,
  output logic              out_grant,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              viol_flag
);
  localparam int MW = 2**ID_W;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ID_W + DATA_W + 1;
  logic [MW-1:0] mask_q, mask_d;
  logic locked_q, locked_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0] count_q, count_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic viol_flag_q, viol_flag_d;
  logic push, pop, grant, cfg_viol, deny_viol;
  logic [CNT_W:0] viol_sum;
  logic [EW-1:0] head, entry;
  assign req_ready = count_q != (PW+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = req_valid && req_ready;
  assign pop = out_valid && out_ready;
  // Decision uses the mask registered before this edge; same-cycle cfg writes apply later.
  assign grant = mask_q[req_id];
  assign entry = {req_id, grant ? req_data : {DATA_W{1'b0}}, grant};
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_id, out_data, out_grant} = head;
  assign locked = locked_q;
  assign viol_cnt = viol_cnt_q;
  assign viol_flag = viol_flag_q;
  always_comb begin
    cfg_viol = cfg_we && locked_q;
    deny_viol = push && !grant;
    mask_d = (cfg_we && !locked_q) ? cfg_mask : mask_q;
    locked_d = (cfg_we && !locked_q) ? cfg_lock : locked_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    viol_sum = {1'b0, viol_cnt_q} + (CNT_W+1)'(cfg_viol) + (CNT_W+1)'(deny_viol);
    viol_cnt_d = viol_sum[CNT_W] ? {CNT_W{1'b1}} : viol_sum[CNT_W-1:0];
    viol_flag_d = viol_flag_q || cfg_viol || deny_viol;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= DEFAULT_MASK;
      locked_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      viol_cnt_q <= '0;
      viol_flag_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      locked_q <= locked_d;
      count_q <= count_d;
      viol_cnt_q <= viol_cnt_d;
      viol_flag_q <= viol_flag_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_usr_access_gate.sv
// tb_usr_access_gate: directed-vector bench for usr_access_gate.
module tb_usr_access_gate;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, cfg_we, cfg_lock, locked;
  logic out_valid, out_ready, out_grant, viol_flag;
  logic [2:0] req_id, out_id;
  logic [7:0] req_data, cfg_mask, out_data, viol_cnt;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  usr_access_gate dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .cfg_lock(cfg_lock), .locked(locked), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_grant(out_grant),
    .viol_cnt(viol_cnt), .viol_flag(viol_flag)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  task automatic head(input string tag, input logic [2:0] id, input logic [7:0] d, input logic g);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_id"}, out_id, id);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_grant"}, out_grant, g);
  endtask
  task automatic req(input logic [2:0] id, input logic [7:0] d);
    req_valid = 1'b1;
    req_id = id;
    req_data = d;
    step();
    req_valid = 1'b0;
  endtask
  initial begin
    int sent, rcv;
    rst_n = 0; req_valid = 0; req_id = 0; req_data = 0;
    cfg_we = 0; cfg_mask = 0; cfg_lock = 0; out_ready = 0;
    step(); step();
    rst_n = 1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_head", {out_id, out_data, out_grant}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_viol", {viol_flag, viol_cnt}, 0);
    req(3'd4, 8'hA5);
    head("t1", 3'd4, 8'hA5, 1);
    chk("t1_viol", viol_cnt, 0);
    req(3'd2, 8'h3C);
    chk("t2_order", out_id, 4);
    chk("t2_viol", viol_cnt, 1);
    chk("t2_flag", viol_flag, 1);
    pop();
    head("t2", 3'd2, 8'h00, 0);
    pop();
    chk("t2_empty", out_valid, 0);
    cfg_we = 1; cfg_mask = 8'h04;
    req_valid = 1; req_id = 3'd2; req_data = 8'h5A;
    step();
    cfg_we = 0;
    req(3'd2, 8'h77);
    head("t3a", 3'd2, 8'h00, 0);
    chk("t3_viol", viol_cnt, 2);
    pop();
    head("t3b", 3'd2, 8'h77, 1);
    pop();
    cfg_we = 1; cfg_mask = 8'h01; cfg_lock = 1;
    step();
    cfg_we = 0; cfg_lock = 0;
    chk("t4_locked", locked, 1);
    chk("t4_viol0", viol_cnt, 2);
    cfg_we = 1; cfg_mask = 8'hFF;
    step();
    cfg_we = 0;
    chk("t4_viol1", viol_cnt, 3);
    chk("t4_still_locked", locked, 1);
    req(3'd0, 8'h11);
    req(3'd4, 8'h44);
    chk("t4_viol2", viol_cnt, 4);
    head("t4a", 3'd0, 8'h11, 1);
    pop();
    head("t4b", 3'd4, 8'h00, 0);
    pop();
    cfg_we = 1; cfg_mask = 8'hFF;
    req_valid = 1; req_id = 3'd3; req_data = 8'h33;
    step();
    cfg_we = 0; req_valid = 0;
    chk("t4_viol_dual", viol_cnt, 6);
    head("t4c", 3'd3, 8'h00, 0);
    pop();
    chk("t4_empty", out_valid, 0);
    for (int i = 0; i < 4; i++) req(3'd0, 8'hC0 + 8'(i));
    chk("t5_full", req_ready, 0);
    req_valid = 1; req_id = 3'd0; req_data = 8'hD5;
    step();
    chk("t5_held_ready", req_ready, 0);
    head("t5_held", 3'd0, 8'hC0, 1);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("t5_freed", req_ready, 1);
    req_valid = 0;
    for (int i = 1; i < 4; i++) begin
      chk("t5_drain", out_data, 8'hC0 + 8'(i));
      pop();
    end
    chk("t5_drained", out_valid, 0);
    sent = 0; rcv = 0;
    out_ready = 1;
    for (int c = 0; c < 60 && rcv < 20; c++) begin
      if (out_valid) begin
        chk("t5_stream", out_data, 8'h80 + 8'(rcv));
        rcv++;
      end
      req_valid = sent < 20;
      req_data = 8'h80 + 8'(sent);
      if (req_valid && req_ready) sent++;
      step();
    end
    req_valid = 0; out_ready = 0;
    chk("t5_stream_count", rcv, 20);
    for (int i = 0; i < 3; i++) req(3'd0, 8'hE0 + 8'(i));
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_valid", out_valid, 0);
    chk("t6_locked", locked, 0);
    chk("t6_ready", req_ready, 1);
    chk("t6_viol", {viol_flag, viol_cnt}, 0);
    req(3'd4, 8'h4A);
    head("t6_mask4", 3'd4, 8'h4A, 1);
    req(3'd0, 8'h0B);
    chk("t6_viol1", viol_cnt, 1);
    pop();
    head("t6_mask0", 3'd0, 8'h00, 0);
    pop();
    out_ready = 1; req_valid = 1; req_id = 3'd2; req_data = 8'h99;
    repeat (253) step();
    chk("t6_cnt254", viol_cnt, 254);
    step();
    chk("t6_cnt255", viol_cnt, 255);
    repeat (46) step();
    req_valid = 0;
    chk("t6_sat", viol_cnt, 255);
    chk("t6_flag", viol_flag, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
